// File: rtl/tern_mult_feeder.sv
// tern_mult_feeder: byte-stream front end that loads ternary weights, feeds activation pairs and drains results
// Ports: clk/rst (sync, active-high); i_in_data/i_in_valid/i_in_is_w/o_in_ready byte input stream;
//        o_mult_row/o_mult_vec/o_mult_w drive the multiplier, i_mult_out returns its result byte;
//        o_res_data/o_res_valid/i_res_ready result stream; o_w_err sticky illegal-weight flag.
// Option: define TERN_WCHK_EN to scrub weight code 2'b11 to 2'b00 and flag it on o_w_err.
module tern_mult_feeder #(
    parameter int InLen    = 14,
    parameter int OutLen   = 7,
    parameter int BitWidth = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BitWidth-1:0]   i_in_data,
    input  logic                  i_in_valid,
    input  logic                  i_in_is_w,
    output logic                  o_in_ready,
    output logic [2:0]            o_mult_row,
    output logic [2*BitWidth-1:0] o_mult_vec,
    output logic [2*InLen-1:0]    o_mult_w,
    input  logic [BitWidth-1:0]   i_mult_out,
    output logic [BitWidth-1:0]   o_res_data,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic                  o_w_err
);
    localparam int WW = 2*InLen;
    localparam logic [2:0] LAST_K = 3'(OutLen-1);
    typedef enum logic [2:0] {IDLE, W_LOAD, VEC_LO, VEC_HI, LATCH, DRAIN_SET, DRAIN_OUT} state_t;
    state_t                r_state;
    logic                  r_in_ready;
    logic [2:0]            r_row;
    logic [2*BitWidth-1:0] r_vec;
    logic [WW-1:0]         r_w;
    logic [BitWidth-1:0]   r_res;
    logic                  r_res_valid;
    logic [BitWidth-1:0]   r_lo;
    logic [2:0]            r_step;
    logic [2:0]            r_k;
    logic [1:0]            r_widx;
    logic                  r_cnt;
    logic                  w_acc;
    logic [BitWidth-1:0]   w_byte;
    logic [WW-1:0]         w_sh;
    logic [WW-1:0]         w_mask;
    logic [WW-1:0]         w_wnext;
    assign w_acc = i_in_valid & r_in_ready;
`ifdef TERN_WCHK_EN
    logic [3:0] w_hit;
    logic [3:0] w_keep;
    logic       w_is_wbyte;
    logic       r_err;
    always_comb begin
        w_byte = i_in_data;
        w_hit  = '0;
        for (int n = 0; n < 4; n++) begin
            if (i_in_data[2*n+:2] == 2'b11) begin
                w_byte[2*n+:2] = 2'b00;
                w_hit[n]       = 1'b1;
            end
        end
    end
    // Byte 3 only carries two weights; its upper nibble is dropped and cannot be illegal.
    assign w_keep     = (r_widx == 2'd3) ? 4'b0011 : 4'b1111;
    assign w_is_wbyte = w_acc & (((r_state == IDLE) & i_in_is_w) | (r_state == W_LOAD));
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_is_wbyte && |(w_hit & w_keep))
            r_err <= 1'b1;
    end
    assign o_w_err = r_err;
`else
    assign w_byte  = i_in_data;
    assign o_w_err = 1'b0;
`endif
    // Byte k lands at bit 8k; shifting in a WW-bit frame truncates byte 3 to its low nibble.
    assign w_sh    = WW'(w_byte) << {r_widx, 3'b000};
    assign w_mask  = {{(WW-8){1'b0}}, 8'hFF} << {r_widx, 3'b000};
    assign w_wnext = (r_w & ~w_mask) | w_sh;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_row       <= '0;
            r_vec       <= '0;
            r_w         <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_lo        <= '0;
            r_step      <= '0;
            r_k         <= '0;
            r_widx      <= '0;
            r_cnt       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_acc) begin
                    if (i_in_is_w) begin
                        r_w     <= w_wnext;
                        r_widx  <= 2'd1;
                        r_state <= W_LOAD;
                    end else begin
                        r_lo    <= i_in_data;
                        r_step  <= '0;
                        r_state <= VEC_HI;
                    end
                end
                W_LOAD: if (w_acc) begin
                    r_w    <= w_wnext;
                    r_widx <= r_widx + 2'd1;
                    if (r_widx == 2'd3) r_state <= IDLE;
                end
                VEC_LO: if (w_acc) begin
                    r_lo    <= i_in_data;
                    r_state <= VEC_HI;
                end
                VEC_HI: if (w_acc) begin
                    r_vec  <= {i_in_data, r_lo};
                    r_row  <= r_step;
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_state    <= LATCH;
                        r_in_ready <= 1'b0;
                        r_cnt      <= 1'b0;
                    end else begin
                        r_state <= VEC_LO;
                    end
                end
                LATCH: begin
                    r_row <= '0;
                    r_vec <= '0;
                    r_cnt <= 1'b1;
                    if (r_cnt) begin
                        r_k     <= '0;
                        r_state <= DRAIN_SET;
                    end
                end
                DRAIN_SET: begin
                    r_res       <= i_mult_out;
                    r_res_valid <= 1'b1;
                    r_state     <= DRAIN_OUT;
                end
                DRAIN_OUT: if (i_res_ready) begin
                    r_res_valid <= 1'b0;
                    if (r_k == LAST_K) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_row   <= r_k + 3'd1;
                        r_state <= DRAIN_SET;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_in_ready  = r_in_ready;
    assign o_mult_row  = r_row;
    assign o_mult_vec  = r_vec;
    assign o_mult_w    = r_w;
    assign o_res_data  = r_res;
    assign o_res_valid = r_res_valid;
endmodule

// File: tb/tb_tern_mult_feeder.sv
// tb_tern_mult_feeder: directed-vector bench for tern_mult_feeder
module tb_tern_mult_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_is_w;
    logic        in_ready;
    logic [2:0]  mult_row;
    logic [15:0] mult_vec;
    logic [27:0] mult_w;
    logic [7:0]  mult_out;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        res_ready;
    logic        w_err;
    int          n_vec = 0;
    int          n_err = 0;
    always #5 clk = ~clk;
    assign mult_out = 8'h30 + {5'b0, mult_row};
    tern_mult_feeder dut (
        .clk(clk), .rst(rst),
        .i_in_data(in_data), .i_in_valid(in_valid), .i_in_is_w(in_is_w), .o_in_ready(in_ready),
        .o_mult_row(mult_row), .o_mult_vec(mult_vec), .o_mult_w(mult_w), .i_mult_out(mult_out),
        .o_res_data(res_data), .o_res_valid(res_valid), .i_res_ready(res_ready), .o_w_err(w_err)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [7:0] d, input bit w);
        bit ok = 1'b0;
        in_data  = d;
        in_is_w  = w;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", {31'b0, ok}, 1);
    endtask
    task automatic drain(input bit tog);
        int         nh    = 0;
        bit         stall = 1'b0;
        logic [7:0] held  = '0;
        for (int c = 0; c < 200 && nh < 7; c++) begin
            @(negedge clk);
            res_ready = tog ? c[0] : 1'b1;
            chk("drain_rdy_low", {31'b0, in_ready}, 0);
            if (stall) begin
                chk("res_valid_hold", {31'b0, res_valid}, 1);
                chk("res_stable", {24'b0, res_data}, {24'b0, held});
            end
            stall = res_valid && !res_ready;
            held  = res_data;
            if (res_valid && res_ready) begin
                chk("res_data", {24'b0, res_data}, 32'h30 + nh);
                nh++;
            end
        end
        chk("drain_cnt", nh, 7);
        @(negedge clk);
        chk("rdy_rise", {31'b0, in_ready}, 1);
        res_ready = 1'b0;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, {31'b0, in_ready}, 1);
        chk({tag, "_row"}, {29'b0, mult_row}, 0);
        chk({tag, "_vec"}, {16'b0, mult_vec}, 0);
        chk({tag, "_w"}, {4'b0, mult_w}, 0);
        chk({tag, "_rvalid"}, {31'b0, res_valid}, 0);
        chk({tag, "_rdata"}, {24'b0, res_data}, 0);
        chk({tag, "_werr"}, {31'b0, w_err}, 0);
    endtask
    logic [7:0] wb [4] = '{8'h55, 8'hAA, 8'h11, 8'hF4};
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_is_w = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("rst0");
        for (int i = 0; i < 4; i++) begin
            send(wb[i], 1'b1);
            chk("w_rdy", {31'b0, in_ready}, 1);
        end
        in_valid = 1'b0;
        chk("w_load", {4'b0, mult_w}, 32'h0411AA55);
        for (int s = 0; s < 8; s++) begin
            send(8'(2*s+1), 1'b0);
            if (s > 0) chk("vec_hold", {16'b0, mult_vec}, {16'b0, 8'(2*s), 8'(2*s-1)});
            send(8'(2*s+2), 1'b0);
            chk("vec_pair", {16'b0, mult_vec}, {16'b0, 8'(2*s+2), 8'(2*s+1)});
            chk("vec_row", {29'b0, mult_row}, s);
        end
        chk("rdy_drop", {31'b0, in_ready}, 0);
        in_data = 8'h21;
        in_is_w = 1'b0;
        drain(1'b1);
        chk("w_persist", {4'b0, mult_w}, 32'h0411AA55);
        @(posedge clk);
        #1;
        send(8'h22, 1'b0);
        chk("b2b_pair0", {16'b0, mult_vec}, 32'h2221);
        chk("b2b_row0", {29'b0, mult_row}, 0);
        for (int s = 1; s < 8; s++) begin
            send(8'(8'h21 + 2*s), 1'b0);
            send(8'(8'h22 + 2*s), 1'b0);
        end
        chk("b2b_pair7", {16'b0, mult_vec}, 32'h302F);
        chk("b2b_row7", {29'b0, mult_row}, 7);
        drain(1'b0);
        in_valid = 1'b0;
        send(8'h99, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("rst_mid");
        send(8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) send(8'h00, 1'b1);
        in_valid = 1'b0;
`ifdef TERN_WCHK_EN
        chk("wchk_scrub", {4'b0, mult_w}, 0);
        chk("wchk_err", {31'b0, w_err}, 1);
        send(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send(8'h00, 1'b1);
        in_valid = 1'b0;
        chk("wchk_w2", {4'b0, mult_w}, 1);
        chk("wchk_sticky", {31'b0, w_err}, 1);
`else
        chk("wff_pass", {4'b0, mult_w}, 32'hFF);
        chk("wff_noerr", {31'b0, w_err}, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tern_mult_feeder.md
# tern_mult_feeder

Byte-stream front end for the ternary matrix-vector multiplier. Accepts a handshaked byte stream from the pin interface and loads the 2×7 ternary weight register. Assembles activation byte pairs and drives them with the row index into the multiplier, then drains the OutLen result bytes back out over a valid/ready port. It is the producer/consumer counterpart of the multiplier: it generates `row`, `VecIn` and `W`, and it collects `VecOut`.

## Interface
- InLen, 14, number of ternary weights held (2 rows × 7 cols); weight register is 2*InLen bits
- OutLen, 7, result bytes drained per frame
- BitWidth, 8, activation and result width
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous, active-high reset
- in_data  in  BitWidth  stream byte
- in_valid  in  1  in_data valid
- in_is_w  in  1  sampled only on the first byte of a frame; 1 = weight frame, 0 = vector frame
- in_ready  out  1  feeder accepts in_data this cycle
- mult_row  out  3  row index to multiplier
- mult_vec  out  2*BitWidth  activation pair, low byte = first received
- mult_w  out  2*InLen  ternary weights, 2 bits per weight, {neg,pos}
- mult_out  in  BitWidth  multiplier result byte for current mult_row
- res_data  out  BitWidth  drained result byte
- res_valid  out  1  res_data valid
- res_ready  in  1  consumer accepts res_data
- w_err  out  1  sticky illegal-weight flag (see Configuration)

## Operation
- Accept rule: a byte transfers on a rising edge where in_valid & in_ready.
- States: IDLE, W_LOAD, VEC_LO, VEC_HI, LATCH, DRAIN_SET, DRAIN_OUT.
- IDLE: in_ready=1. On the first accepted byte:
  - in_is_w=1 -> byte is weight byte 0; go to W_LOAD.
  - in_is_w=0 -> byte is the low activation byte of step 0; go to VEC_HI.
- W_LOAD: accepts bytes 1..3. Byte k fills mult_w[8k+:8], truncated to 2*InLen bits, so byte 3 upper nibble is discarded. After byte 3 -> IDLE.
- VEC_LO: accepts the low byte of step s. Then -> VEC_HI.
- VEC_HI: accepts the high byte.
  - Next edge: mult_vec={hi,lo}, mult_row=s.
  - s<7: s+1, go to VEC_LO. s=7: go to LATCH.
  - Step 0 always drives mult_row=0, which clears the multiplier accumulators.
- LATCH: in_ready=0. Drives mult_row=0 and mult_vec=0 for 2 cycles so the multiplier latches its 8-step sums. Then k=0 and go to DRAIN_SET.
- DRAIN_SET: mult_row=k, held 1 cycle. Then go to DRAIN_OUT.
- DRAIN_OUT: res_data=mult_out sampled on entry, res_valid=1, held until res_ready.
  - On the handshake: k<OutLen-1 -> k+1, go to DRAIN_SET. Otherwise -> IDLE.
- mult_w is unchanged by vector frames; it persists until the next weight frame or reset.
- Arithmetic: none; pure sequencing and bit packing.

## Timing
- Reset values:
  - State: IDLE.
  - in_ready=1.
  - mult_row=0, mult_vec=0, mult_w=0.
  - res_data=0, res_valid=0, w_err=0.
- Reset mid-frame abandons the frame and clears the weights. No partial results are emitted.
- Each activation pair is held on mult_vec/mult_row for at least 2 full clk periods, because the next pair needs 2 accepts. The multiplier's negedge sampling sees it stably.
- Throughput:
  - Vector frame: 16 accepted bytes + 2 LATCH cycles + OutLen×(1 + res wait) cycles.
  - Minimum frame: 16 + 2 + 14 = 32 cycles with in_valid and res_ready held high.
- in_ready drops the cycle after the 16th byte is accepted, and rises the cycle after the last result handshake.
- res_valid never drops without a handshake; res_data stays stable while res_valid & !res_ready.
- in_valid during LATCH/DRAIN is ignored (in_ready=0). No byte is lost or consumed.

## Configuration
- TERN_WCHK_EN defined:
  - Each weight code 2'b11 is replaced by 2'b00 in mult_w.
  - w_err is set the cycle after the offending byte is accepted, and clears only on rst.
- Undefined:
  - Codes pass through unchanged; the multiplier treats 2'b11 as -1.
  - w_err is tied to 0.

## Test plan
- Reset: assert rst for 2 cycles mid-VEC_HI -> all outputs equal the reset values, in_ready=1, mult_w=0.
- Weight load: stream 0x55, 0xAA, 0x11, 0xF4 with in_is_w=1 -> mult_w=28'h411AA55, in_ready stays 1, state returns to IDLE.
- Vector frame: 16 bytes 0x01..0x10 with in_is_w=0 -> mult_row steps 0..7 and mult_vec shows 0x0201, 0x0403, ... 0x100F. Each value is held ≥2 cycles; in_ready=0 after the 16th byte.
- Drain backpressure: model mult_out=0x30+mult_row, toggle res_ready every other cycle -> res_data sequence 0x30..0x36, 7 handshakes, res_data stable while stalled, then IDLE.
- Back-to-back: in_valid held high across two frames -> no bytes accepted during LATCH/DRAIN, and the second frame's step-0 pair arrives with mult_row=0.
- TERN_WCHK_EN: weight byte 0xFF -> low 4 weights read 2'b00 in mult_w, w_err=1 and sticky. Without the macro: mult_w byte=0xFF, w_err=0.
